// File: rtl/uart_ddfs_baud_if.sv
// Control/status bundle between the UART core and its DDFS baud generator.
// The master modport drives tuning/RX control; the slave modport is the generator.
interface uart_ddfs_baud_if #(
    parameter int unsigned W = 16
) ();
    logic         EN;
    logic         K_WR;
    logic [W-1:0] K_IN;
    logic         RX_SYNC;
    logic         RX_STOP;
    logic         CLK_RX;
    logic         CLK_TX;
    logic         RX_SAMPLE;
    logic         K_PEND;
    logic [W-1:0] K_CUR;

    modport master (
        output EN, K_WR, K_IN, RX_SYNC, RX_STOP,
        input  CLK_RX, CLK_TX, RX_SAMPLE, K_PEND, K_CUR
    );

    modport slave (
        input  EN, K_WR, K_IN, RX_SYNC, RX_STOP,
        output CLK_RX, CLK_TX, RX_SAMPLE, K_PEND, K_CUR
    );
endinterface

// File: rtl/uart_ddfs_baud.sv
// DDFS baud generator: one phase accumulator yields the oversample tick and bit tick,
// with glitch-free tuning updates at TX bit boundaries and a resyncable RX mid-bit strobe.
module uart_ddfs_baud #(
    parameter int unsigned W      = 16,
    parameter int unsigned OVS    = 16,
    parameter int unsigned K_INIT = 2416
) (
    input  logic             CLK,
    input  logic             RST,
    uart_ddfs_baud_if.slave  bus
);
    localparam int unsigned CW       = $clog2(OVS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic [W-1:0]  K_RST    = W'(K_INIT);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  k_cur_q, k_cur_d;
    logic [W-1:0]  k_shadow_q, k_shadow_d;
    logic          k_pend_q, k_pend_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_act_q, rx_act_d;
    logic          clk_rx_q, clk_rx_d;
    logic          clk_tx_q, clk_tx_d;
    logic          rx_sample_q, rx_sample_d;

    logic [W:0]    sum;
    logic          carry;
    logic          boundary;

    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, k_cur_q};
        carry    = bus.EN & sum[W];
        boundary = carry & (tx_cnt_q == CNT_LAST);

        acc_d       = bus.EN ? sum[W-1:0] : acc_q;
        tx_cnt_d    = carry ? tx_cnt_q + 1'b1 : tx_cnt_q;
        clk_rx_d    = carry;
        clk_tx_d    = boundary;

        k_cur_d    = k_cur_q;
        k_shadow_d = k_shadow_q;
        k_pend_d   = k_pend_q;
        // A write always defers the apply by at least one edge, even on a boundary.
        if (bus.K_WR) begin
            k_shadow_d = bus.K_IN;
            k_pend_d   = 1'b1;
        end else if (k_pend_q && (!bus.EN || boundary)) begin
            k_cur_d  = k_shadow_q;
            k_pend_d = 1'b0;
        end

        rx_cnt_d    = rx_cnt_q;
        rx_act_d    = rx_act_q;
        rx_sample_d = 1'b0;
        if (bus.RX_SYNC) begin
            rx_cnt_d = '0;
            rx_act_d = 1'b1;
        end else if (bus.RX_STOP) begin
            rx_cnt_d = '0;
            rx_act_d = 1'b0;
        end else if (carry && rx_act_q) begin
            rx_cnt_d    = rx_cnt_q + 1'b1;
            rx_sample_d = (rx_cnt_q == CNT_HALF);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q       <= '0;
            k_cur_q     <= K_RST;
            k_shadow_q  <= K_RST;
            k_pend_q    <= 1'b0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            rx_act_q    <= 1'b0;
            clk_rx_q    <= 1'b0;
            clk_tx_q    <= 1'b0;
            rx_sample_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            k_cur_q     <= k_cur_d;
            k_shadow_q  <= k_shadow_d;
            k_pend_q    <= k_pend_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_act_q    <= rx_act_d;
            clk_rx_q    <= clk_rx_d;
            clk_tx_q    <= clk_tx_d;
            rx_sample_q <= rx_sample_d;
        end
    end

    assign bus.CLK_RX    = clk_rx_q;
    assign bus.CLK_TX    = clk_tx_q;
    assign bus.RX_SAMPLE = rx_sample_q;
    assign bus.K_PEND    = k_pend_q;
    assign bus.K_CUR     = k_cur_q;
endmodule

// File: tb/tb_uart_ddfs_baud.sv
// Directed bench for uart_ddfs_baud: expected pulse timestamps are queued with the
// stimulus and matched against pulses captured from the DUT.
module tb_uart_ddfs_baud;
    typedef int unsigned uq_t[$];

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    int unsigned cyc = 0;
    int unsigned t0  = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    uq_t exp_rx, exp_tx, exp_smp;
    uq_t obs_rx, obs_tx, obs_smp;

    uart_ddfs_baud_if #(.W(16)) bus ();

    uart_ddfs_baud #(
        .W      (16),
        .OVS    (16),
        .K_INIT (4096)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always begin
        @(posedge CLK);
        #1;
        if (bus.CLK_RX === 1'b1)    obs_rx.push_back(cyc);
        if (bus.CLK_TX === 1'b1)    obs_tx.push_back(cyc);
        if (bus.RX_SAMPLE === 1'b1) obs_smp.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drain(input string tag, input uq_t e, input uq_t o);
        chk({tag, "_count"}, 32'(o.size()), 32'(e.size()));
        while (e.size() > 0 && o.size() > 0)
            chk({tag, "_time"}, o.pop_front() - t0, e.pop_front() - t0);
    endtask

    task automatic drain_all();
        drain("clk_rx", exp_rx, obs_rx);
        drain("clk_tx", exp_tx, obs_tx);
        drain("rx_sample", exp_smp, obs_smp);
        exp_rx.delete(); exp_tx.delete(); exp_smp.delete();
        obs_rx.delete(); obs_tx.delete(); obs_smp.delete();
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < t0 + n) @(negedge CLK);
    endtask

    task automatic write_k(input logic [15:0] k);
        bus.K_WR = 1'b1;
        bus.K_IN = k;
        @(negedge CLK);
        bus.K_WR = 1'b0;
    endtask

    task automatic pulse_sync();
        bus.RX_SYNC = 1'b1;
        @(negedge CLK);
        bus.RX_SYNC = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.RX_STOP = 1'b1;
        @(negedge CLK);
        bus.RX_STOP = 1'b0;
    endtask

    task automatic push_range(input int sel, input int unsigned first, input int unsigned last,
                              input int unsigned step);
        for (int unsigned t = first; t <= last; t += step) begin
            case (sel)
                0:       exp_rx.push_back(t0 + t);
                1:       exp_tx.push_back(t0 + t);
                default: exp_smp.push_back(t0 + t);
            endcase
        end
    endtask

    initial begin
        int unsigned nbad;
        bus.EN = 1'b0; bus.K_WR = 1'b0; bus.K_IN = '0;
        bus.RX_SYNC = 1'b0; bus.RX_STOP = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_clk_rx", 32'(bus.CLK_RX), 0);
        chk("rst_clk_tx", 32'(bus.CLK_TX), 0);
        chk("rst_rx_sample", 32'(bus.RX_SAMPLE), 0);
        chk("rst_k_pend", 32'(bus.K_PEND), 0);
        chk("rst_k_cur", 32'(bus.K_CUR), 4096);

        // K=4096 from reset: CLK_RX every 16, first at 16; CLK_TX at 256
        RST = 1'b0; bus.EN = 1'b1; t0 = cyc;
        push_range(0, 16, 256, 16);
        push_range(1, 256, 256, 1);
        wait_until(260);
        drain_all();

        // Mid-bit write of 8192, applied at the next TX boundary
        push_range(0, 272, 512, 16);
        push_range(0, 520, 640, 8);
        push_range(1, 512, 640, 128);
        wait_until(380);
        write_k(16'd8192);
        chk("wr1_pend", 32'(bus.K_PEND), 1);
        chk("wr1_cur_old", 32'(bus.K_CUR), 4096);
        wait_until(511);
        chk("wr1_pend_before_bnd", 32'(bus.K_PEND), 1);
        wait_until(512);
        chk("wr1_pend_after_bnd", 32'(bus.K_PEND), 0);
        chk("wr1_cur_new", 32'(bus.K_CUR), 8192);
        wait_until(644);
        drain_all();

        // Two writes before the boundary: only the last one lands
        push_range(0, 648, 768, 8);
        push_range(0, 800, 1280, 32);
        push_range(1, 768, 1280, 512);
        wait_until(699);
        write_k(16'd16384);
        wait_until(719);
        write_k(16'd2048);
        chk("wr2_pend", 32'(bus.K_PEND), 1);
        chk("wr2_cur_old", 32'(bus.K_CUR), 8192);
        wait_until(767);
        chk("wr2_pend_before_bnd", 32'(bus.K_PEND), 1);
        wait_until(768);
        chk("wr2_cur_last", 32'(bus.K_CUR), 2048);
        chk("wr2_pend_after_bnd", 32'(bus.K_PEND), 0);
        wait_until(1282);
        drain_all();

        // EN=0 write applies on the next edge; acc holds while stopped
        wait_until(1290);
        bus.EN = 1'b0;
        write_k(16'd4096);
        chk("en0_pend", 32'(bus.K_PEND), 1);
        chk("en0_cur_old", 32'(bus.K_CUR), 2048);
        @(negedge CLK);
        chk("en0_pend_applied", 32'(bus.K_PEND), 0);
        chk("en0_cur_new", 32'(bus.K_CUR), 4096);
        bus.EN = 1'b1;

        // RX aligner: plain sync, stop, then sync coincident with a carry
        push_range(0, 1303, 2647, 16);
        push_range(1, 1543, 2567, 256);
        push_range(2, 1431, 1943, 256);
        push_range(2, 2391, 2647, 256);
        wait_until(1310);
        pulse_sync();
        wait_until(1950);
        pulse_stop();
        wait_until(2262);
        pulse_sync();
        wait_until(2660);
        drain_all();
        pulse_stop();

        // K=2416 over 2^16 clocks: exact pulse counts and 27/28 spacing
        bus.EN = 1'b0;
        write_k(16'd2416);
        @(negedge CLK);
        chk("k2416_cur", 32'(bus.K_CUR), 2416);
        bus.EN = 1'b1;
        obs_rx.delete(); obs_tx.delete(); obs_smp.delete();
        repeat (65536) @(negedge CLK);
        chk("k2416_rx_count", 32'(obs_rx.size()), 2416);
        chk("k2416_tx_count", 32'(obs_tx.size()), 151);
        chk("k2416_smp_count", 32'(obs_smp.size()), 0);
        nbad = 0;
        for (int i = 1; i < obs_rx.size(); i++) begin
            if (obs_rx[i] - obs_rx[i-1] != 27 && obs_rx[i] - obs_rx[i-1] != 28) nbad++;
        end
        chk("k2416_spacing_bad", nbad, 0);
        obs_rx.delete(); obs_tx.delete(); obs_smp.delete();

        // k_cur=0: no ticks at all
        bus.EN = 1'b0;
        write_k(16'd0);
        @(negedge CLK);
        bus.EN = 1'b1;
        chk("k0_cur", 32'(bus.K_CUR), 0);
        obs_rx.delete(); obs_tx.delete();
        repeat (300) @(negedge CLK);
        chk("k0_rx_count", 32'(obs_rx.size()), 0);
        chk("k0_tx_count", 32'(obs_tx.size()), 0);

        // Reset discards a pending write
        write_k(16'd8192);
        chk("prerst_pend", 32'(bus.K_PEND), 1);
        chk("prerst_cur", 32'(bus.K_CUR), 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_pend", 32'(bus.K_PEND), 0);
        chk("midrst_cur", 32'(bus.K_CUR), 4096);
        chk("midrst_clk_rx", 32'(bus.CLK_RX), 0);
        chk("midrst_clk_tx", 32'(bus.CLK_TX), 0);
        chk("midrst_rx_sample", 32'(bus.RX_SAMPLE), 0);
        RST = 1'b0;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_ddfs_baud.md
# uart_ddfs_baud

Parametrised DDFS baud-rate generator for the UART. It produces a single-cycle oversampling tick (CLK_RX) and a bit-rate tick (CLK_TX) from one phase accumulator, with the tuning word reprogrammable at run time. A baud change is applied glitch-free at a TX bit boundary. An RX phase aligner emits a mid-bit sample strobe locked to a start-bit resync request. It sits between the system clock and the UART RX/TX shift FSMs.

## Interface
- W, 16: accumulator and tuning-word width; f_CLK_RX = f_CLK · k_cur / 2^W.
- OVS, 16: RX oversampling factor; power of two, 4..64.
- K_INIT, 2416: tuning word after reset (115200 bd ×16 at 50 MHz, W=16).
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; one clock, synchronous active-high reset.
- EN  in  1  accumulator run enable.
- K_WR  in  1  write strobe for K_IN.
- K_IN  in  W  new tuning word.
- RX_SYNC  in  1  start-bit edge seen; restart RX phase.
- RX_STOP  in  1  RX frame done; stop RX_SAMPLE generation.
- CLK_RX  out  1  one-cycle pulse at oversample rate.
- CLK_TX  out  1  one-cycle pulse every OVS CLK_RX pulses.
- RX_SAMPLE  out  1  one-cycle pulse at bit centre, RX active only.
- K_PEND  out  1  written tuning word not yet applied.
- K_CUR  out  W  tuning word in use.

## Operation
- State: acc[W-1:0], k_cur, k_shadow, K_PEND, tx_cnt[log2 OVS], rx_cnt[log2 OVS], rx_act.
- Each edge with EN=1: {c, acc} <= acc + k_cur (W+1-bit sum; carry c, acc wraps mod 2^W). With EN=0: acc holds and c=0.
- CLK_RX <= c.
- Each c: tx_cnt <= tx_cnt+1 mod OVS. CLK_TX <= c && tx_cnt==OVS-1.
- Tuning update:
  - K_WR: k_shadow <= K_IN, K_PEND <= 1. No apply on that edge, even if a boundary coincides.
  - Apply when K_PEND && !K_WR && (EN==0 || (c && tx_cnt==OVS-1)): k_cur <= k_shadow, K_PEND <= 0.
  - acc and tx_cnt are not cleared on apply, so the phase is continuous.
  - A second K_WR while pending overwrites k_shadow; only the last value is applied.
- RX aligner:
  - RX_SYNC: rx_cnt <= 0, rx_act <= 1.
  - On c with rx_act and no RX_SYNC: rx_cnt <= rx_cnt+1 mod OVS. RX_SAMPLE <= (rx_cnt == OVS/2-1).
  - RX_SYNC on the same edge as c: RX_SYNC wins for rx_cnt (c not counted for RX). CLK_RX and CLK_TX are unaffected.
  - RX_STOP: rx_act <= 0, rx_cnt <= 0. RX_SYNC and RX_STOP together: RX_SYNC wins.
- RX_SYNC never touches acc or tx_cnt; TX timing is independent of RX.
- k_cur = 0: no ticks, state holds. k_cur ≥ 2^(W-1) is legal; carry occurs at most once per cycle.

## Timing
- All outputs registered. Reset values: CLK_RX=0, CLK_TX=0, RX_SAMPLE=0, K_PEND=0, K_CUR=K_INIT. Internal: acc=0, tx_cnt=0, rx_cnt=0, rx_act=0, k_shadow=K_INIT.
- CLK_RX goes high in the cycle after the carry-producing edge, for exactly one cycle.
- CLK_TX coincides with every OVS-th CLK_RX.
- RX_SAMPLE, first after RX_SYNC: coincides with the (OVS/2)-th CLK_RX pulse counted after the sync edge. Subsequent pulses every OVS CLK_RX pulses.
- K_CUR changes on the edge where CLK_TX is asserted next cycle. The first carry using the new word is on the following edge.
- RST mid-operation: all state returns to reset values on that edge, including a pending write, which is discarded.

## Test plan
- W=16, OVS=16, K_INIT=4096, EN=1 after reset -> CLK_RX every 16 clocks, first at cycle 16 after reset release. CLK_TX every 256 clocks, coinciding with every 16th CLK_RX.
- K_INIT=2416, run 2^16 clocks -> exactly 2416 CLK_RX and 151 CLK_TX pulses; spacing only 27 or 28 clocks.
- K_WR K_IN=8192 at mid-bit -> K_PEND=1 until the next CLK_TX boundary. K_CUR=8192 from then; next CLK_TX 128 clocks later. A second K_WR=2048 before the boundary -> 2048 applied instead.
- RX_SYNC with K=4096 -> RX_SAMPLE on the 8th CLK_RX after sync, then every 256 clocks. RX_STOP -> no further RX_SAMPLE; CLK_TX cadence unchanged throughout.
- RX_SYNC on the same edge as a carry -> that tick is not counted for RX; RX_SAMPLE is 16 clocks later than in the non-coincident case.
- EN=0 with K_WR -> applied next edge. k_cur=0 -> no ticks. RST asserted while K_PEND=1 -> K_PEND=0, K_CUR=K_INIT, all outputs 0 next cycle.
